// File: rtl/pb_debouncer_if.sv
// Push-button signal bundle between the board pin, the debouncer and the
// downstream pulse FSM.
//
// Signalling: there is no valid/ready handshake on this bundle. PB_raw is a
// free-running asynchronous level. PB_status is a registered, debounced level
// that is always valid. PB_pressed / PB_released are registered single-cycle
// strobes that the consumer must sample on every clock; they are never
// asserted together and never held for more than one cycle.
// dbg_state mirrors the debouncer FSM state for observation only.
interface pb_debouncer_if;
    logic       PB_raw;
    logic       PB_status;
    logic       PB_pressed;
    logic       PB_released;
    logic [1:0] dbg_state;

    // Debouncer side: consumes the pin, produces the clean level and strobes.
    modport master (
        input  PB_raw,
        output PB_status,
        output PB_pressed,
        output PB_released,
        output dbg_state
    );

    // Pin / consumer side: drives the raw pin, observes the conditioned outputs.
    modport slave (
        output PB_raw,
        input  PB_status,
        input  PB_pressed,
        input  PB_released,
        input  dbg_state
    );
endinterface

// File: rtl/pb_debouncer.sv
// Push-button debouncer: synchronizes a raw bouncing button pin and accepts a
// level change only after the new level has been seen on N_DEBOUNCER_DELAY
// consecutive synchronized samples following the detecting sample. Produces a
// clean level plus one-cycle press/release strobes, all registered.
module pb_debouncer #(
    parameter int N_DEBOUNCER_DELAY = 5,
    parameter int SYNC_STAGES       = 2
) (
    input  logic         clk,
    input  logic         rst,
    pb_debouncer_if.master bus
);

    localparam int CW = $clog2(N_DEBOUNCER_DELAY);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_DEBOUNCER_DELAY - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    state_t                 state;
    logic [CW-1:0]          count;
    logic                   status_q;
    logic                   pressed_q;
    logic                   released_q;

    // Shift the raw pin through the synchronizer chain; only the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.PB_raw};
        end
    end

    assign sync = sync_ff[SYNC_STAGES-1];

    // Qualification FSM with registered level and strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            status_q   <= 1'b0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state <= PRESS_WAIT;
                        count <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        // Bounced back before qualifying: drop silently.
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state     <= PRESSED;
                        count     <= '0;
                        status_q  <= 1'b1;
                        pressed_q <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state <= RELEASE_WAIT;
                        count <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        // Release glitch: stay pressed, no strobe.
                        state <= PRESSED;
                        count <= '0;
                    end else if (count == CNT_MAX) begin
                        state      <= IDLE;
                        count      <= '0;
                        status_q   <= 1'b0;
                        released_q <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

    assign bus.PB_status   = status_q;
    assign bus.PB_pressed  = pressed_q;
    assign bus.PB_released = released_q;
    assign bus.dbg_state   = state;

endmodule

// File: doc/pb_debouncer.md
Name: pb_debouncer

Overview:
- Conditions a raw, asynchronous, bouncing push-button input into a clean, stable level and single-cycle edge pulses.
- Its PB_status output is the level consumed by the button-to-increment-pulse FSM, so this block is the producing end of that PB_status interface.
- Sits between the board pin and the pulse FSM, in the same single clock domain.

Parameters:
- N_DEBOUNCER_DELAY, 5, consecutive synchronized samples at the new level (after the detecting sample) required before a level change is accepted; legal range >= 2.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- PB_raw  input  1  raw button pin, asynchronous, may bounce; 1 = pressed.
- PB_status  output  1  debounced level; 1 = stable press; registered.
- PB_pressed  output  1  one-cycle pulse on accepted press; registered.
- PB_released  output  1  one-cycle pulse on accepted release; registered.

Behaviour:
- Reset:
  - One clock, synchronous, active-high.
  - Synchronizer flops = 0, state = IDLE, counter = 0, PB_status = 0, PB_pressed = 0, PB_released = 0.
  - Reset asserted mid-operation aborts any qualification in progress, with no output pulse.
- Synchronizer:
  - PB_raw passes through SYNC_STAGES flops; sync = last stage.
  - Only sync feeds the FSM.
- Counter:
  - Width $clog2(N_DEBOUNCER_DELAY).
  - Cleared on every state change; never exceeds N_DEBOUNCER_DELAY-1.
- FSM states and transitions:
  - IDLE (released, stable): sync=1 -> PRESS_WAIT, counter=0; else stay.
  - PRESS_WAIT:
    - sync=0 -> IDLE (glitch rejected, no outputs change).
    - sync=1 and counter==N_DEBOUNCER_DELAY-1 -> PRESSED.
    - Else counter+1.
  - PRESSED (stable press): sync=0 -> RELEASE_WAIT, counter=0; else stay.
  - RELEASE_WAIT:
    - sync=1 -> PRESSED (glitch rejected).
    - sync=0 and counter==N_DEBOUNCER_DELAY-1 -> IDLE.
    - Else counter+1.
- Outputs:
  - PB_status = 1 in PRESSED and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT. It changes only on accepted transitions.
  - PB_pressed = 1 for exactly the one cycle after the PRESS_WAIT->PRESSED edge, coincident with PB_status rising.
  - PB_released = 1 for exactly the one cycle after the RELEASE_WAIT->IDLE edge, coincident with PB_status falling.
  - PB_pressed and PB_released are never high together.
- Latency:
  - Let edge 0 be the first rising edge sampling PB_raw=1 with PB_raw held stable.
  - PB_status and PB_pressed go high after edge SYNC_STAGES+N_DEBOUNCER_DELAY (defaults: edge 7).
  - Release is symmetric.
- Boundaries:
  - A bounce back to the old level resets qualification: counting restarts from 0 on the next entry into the wait state.
  - Any bounce shorter than N_DEBOUNCER_DELAY+1 synchronized samples produces no output change.
  - PB_raw held high through reset: after rst deasserts it is treated as a new press. Synchronizer refill plus full latency apply; PB_pressed fires once.
  - Continuous hold: PB_status stays 1 indefinitely. There is no auto-repeat here; repeat is the downstream FSM's job.

Test Plan:
1. Clean press (defaults): PB_raw 0->1, held 20 cycles -> PB_status rises and PB_pressed pulses exactly once after edge 7; PB_released stays 0.
2. Glitch reject: PB_raw high for 3 cycles, then low -> PB_status, PB_pressed, PB_released stay 0 throughout.
3. Bounce train: PB_raw toggles 1,0,1,1,0,1, then held high -> exactly one PB_pressed, occurring SYNC_STAGES+5 edges after the final 0->1 sample.
4. Clean release after stable press: PB_raw 1->0, held -> PB_status falls and PB_released pulses once after edge 7 from the first 0 sample. A 2-cycle low glitch instead leaves PB_status=1 with no pulse.
5. Reset mid-qualification: rst asserted for 1 cycle while in PRESS_WAIT (counter=3) -> all outputs 0 the next cycle. With PB_raw still high, PB_pressed fires 7 edges after the first post-reset sample.
6. Parameter sweep: N_DEBOUNCER_DELAY=2 and SYNC_STAGES=3, clean press -> PB_pressed after edge 5. Check the one-cycle pulse width and that PB_pressed/PB_released are mutually exclusive across 1000 random-bounce cycles.
